// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Brief    : Multi-cycle shift-add multiplier / restoring divider sequencer
//             producing a {HI, LO} result with one-cycle register enables.
//             Optional macro MULDIV_SIGNED_EN enables signed operation.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic                      op_i,
    input  logic                      is_signed_i,
    input  logic [DATA_WIDTH-1:0]     a_in_i,
    input  logic [DATA_WIDTH-1:0]     b_in_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      hi_en_o,
    output logic                      lo_en_o,
    output logic                      div_by_zero_o,
    output logic [2*DATA_WIDTH-1:0]   result_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]              state_q, state_d;
    logic                    op_q, op_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0]   mq_q, mq_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic [DATA_WIDTH:0]     acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [2*DATA_WIDTH-1:0] result_q, result_d;

    logic                    w_neg_a, w_neg_b, w_b_zero, w_ge;
    logic [DATA_WIDTH-1:0]   w_mag_a, w_mag_b, w_quot_f, w_rem_f;
    logic [DATA_WIDTH:0]     w_sum, w_rem_s, w_diff;
    logic [2*DATA_WIDTH-1:0] w_prod_f, w_fixed;

`ifdef MULDIV_SIGNED_EN
    logic sgn_q, sgn_d;
    assign w_neg_a = sgn_q & a_q[DATA_WIDTH-1];
    assign w_neg_b = sgn_q & b_q[DATA_WIDTH-1];
`else
    logic w_unused_signed;
    assign w_unused_signed = is_signed_i;
    assign w_neg_a         = 1'b0;
    assign w_neg_b         = 1'b0;
`endif

    assign w_mag_a  = w_neg_a ? -a_q : a_q;
    assign w_mag_b  = w_neg_b ? -b_q : b_q;
    assign w_b_zero = (b_q == '0);

    // acc holds the product's upper half (multiply) or partial remainder (divide)
    assign w_sum   = acc_q + (mq_q[0] ? {1'b0, opb_q} : '0);
    assign w_rem_s = {acc_q[DATA_WIDTH-1:0], mq_q[DATA_WIDTH-1]};
    assign w_ge    = (w_rem_s >= {1'b0, opb_q});
    assign w_diff  = w_rem_s - {1'b0, opb_q};

    assign w_quot_f = (w_neg_a ^ w_neg_b) ? -mq_q : mq_q;
    assign w_rem_f  = w_neg_a ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    assign w_prod_f = (w_neg_a ^ w_neg_b) ? -{acc_q[DATA_WIDTH-1:0], mq_q}
                                          :  {acc_q[DATA_WIDTH-1:0], mq_q};
    assign w_fixed  = !op_q    ? w_prod_f :
                      w_b_zero ? {a_q, {DATA_WIDTH{1'b1}}} :
                                 {w_rem_f, w_quot_f};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mq_d     = mq_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef MULDIV_SIGNED_EN
        sgn_d    = sgn_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    a_d     = a_in_i;
                    b_d     = b_in_i;
`ifdef MULDIV_SIGNED_EN
                    sgn_d   = is_signed_i;
`endif
                    state_d = c_LOAD;
                end
            end
            c_LOAD: begin
                acc_d   = '0;
                mq_d    = op_q ? w_mag_a : w_mag_b;
                opb_d   = op_q ? w_mag_b : w_mag_a;
                cnt_d   = CW'(DATA_WIDTH - 1);
                state_d = c_RUN;
            end
            c_RUN: begin
                if (op_q) begin
                    acc_d = w_ge ? w_diff : w_rem_s;
                    mq_d  = {mq_q[DATA_WIDTH-2:0], w_ge};
                end else begin
                    acc_d = {1'b0, w_sum[DATA_WIDTH:1]};
                    mq_d  = {w_sum[0], mq_q[DATA_WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = c_FIX;
                end
            end
            c_FIX: begin
                acc_d   = {1'b0, w_fixed[2*DATA_WIDTH-1:DATA_WIDTH]};
                mq_d    = w_fixed[DATA_WIDTH-1:0];
                state_d = c_DONE;
            end
            c_DONE: begin
                result_d = {acc_q[DATA_WIDTH-1:0], mq_q};
                state_d  = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Status flags lag the state by one edge so busy/done line up with the result update
    assign busy_d = (state_q == c_LOAD) || (state_q == c_RUN) || (state_q == c_FIX);
    assign done_d = (state_q == c_DONE);
    assign dbz_d  = (state_q == c_DONE) && op_q && w_b_zero;

    always_ff @(posedge clock_i or negedge clear_i) begin
        if (!clear_i) begin
            state_q  <= c_IDLE;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mq_q     <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mq_q     <= mq_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= sgn_d;
`endif
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign hi_en_o       = done_q;
    assign lo_en_o       = done_q;
    assign div_by_zero_o = dbz_q;
    assign result_o      = result_q;

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the 64-bit HI/LO result register pair. Accepts two DATA_WIDTH-bit operands on a start pulse, runs a shift-add multiplier or restoring divider for DATA_WIDTH iterations, then presents a 2·DATA_WIDTH result with one-cycle HI/LO load enables that drive the enable inputs of the HI and LO registers. It sits beside the ALU and lets the CPU control unit treat MUL/DIV as fixed-latency operations.

## Interface
- DATA_WIDTH, 32, operand width; result width is 2·DATA_WIDTH.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide; captured with start.
- is_signed  in  1  signed operation; captured with start; ignored unless MULDIV_SIGNED_EN.
- a_in  in  DATA_WIDTH  multiplicand / dividend; captured with start.
- b_in  in  DATA_WIDTH  multiplier / divisor; captured with start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse; result valid.
- hi_en  out  1  HI register enable; pulses with done.
- lo_en  out  1  LO register enable; pulses with done.
- div_by_zero  out  1  valid with done; high only for divide with b = 0.
- result  out  2·DATA_WIDTH  {HI, LO}; held until the next start is accepted.

## Operation
- States: IDLE → LOAD → RUN → FIX → DONE → IDLE.
- IDLE: start = 1 latches op, is_signed, a_in, b_in; next LOAD. Otherwise stay.
- LOAD: form operand magnitudes (signed mode) or copy raw operands; clear accumulator; iteration counter = DATA_WIDTH−1.
- RUN: one iteration per cycle, exactly DATA_WIDTH cycles; exits to FIX when counter reaches 0.
  - Multiply: if multiplier LSB = 1, add multiplicand into upper half; shift {acc, multiplier} right 1.
  - Divide (restoring): shift {rem, quot} left 1; if rem ≥ divisor, subtract and set quotient LSB.
- FIX: apply sign correction (signed mode); otherwise pass-through. Always occupies one cycle.
- DONE: drive result; assert done, hi_en, lo_en for exactly one cycle; next IDLE.
- Result format: multiply → full 2·DATA_WIDTH product; divide → HI = remainder, LO = quotient.
- Signed rules: product negated if operand signs differ; quotient truncates toward zero; remainder takes sign of dividend. Most-negative ÷ −1 → LO = 0x8000_0000, HI = 0 (no trap).
- Divide by zero: no early exit; LO = all ones, HI = original dividend (unsigned or signed), div_by_zero = 1.
- start while busy: ignored, no queuing.
- All arithmetic internal at DATA_WIDTH+1 bits; carries out of the top bit discarded.

## Timing
- Reset (clear = 0, any time, including mid-RUN): state IDLE; busy, done, hi_en, lo_en, div_by_zero = 0; result = 0. No done is produced for an aborted operation.
- Start accepted at rising edge k → busy high from edge k+1 → done/hi_en/lo_en high from edge k+DATA_WIDTH+3 for one cycle (35 cycles for DATA_WIDTH = 32); busy low at the same edge done rises.
- Latency independent of operands, op and signedness.
- Earliest next start: sampled at the edge ending the done cycle (back-to-back throughput DATA_WIDTH+4 cycles).
- result stable from done until the edge after the next start acceptance.

## Configuration
- MULDIV_SIGNED_EN defined: is_signed honoured; LOAD takes magnitudes, FIX applies sign rules above.
- Not defined: is_signed ignored; all operations unsigned; FIX is a one-cycle pass-through (latency unchanged).

## Test plan
- Unsigned mul 7 × 6, start at edge 0 → done at edge 35, result 0x0000_0000_0000_002A, hi_en = lo_en = 1 for one cycle.
- Unsigned mul 0xFFFF_FFFF × 0xFFFF_FFFF → result 0xFFFF_FFFE_0000_0001.
- Unsigned div 100 ÷ 7 → HI = 2, LO = 14, div_by_zero = 0; div 5 ÷ 0 → HI = 5, LO = 0xFFFF_FFFF, div_by_zero = 1.
- With MULDIV_SIGNED_EN: −3 × 5 → 0xFFFF_FFFF_FFFF_FFF1; −7 ÷ 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF; 0x8000_0000 ÷ −1 → LO = 0x8000_0000, HI = 0.
- start re-pulsed at cycle 10 of a running mul → ignored; original result delivered at edge 35.
- clear low at cycle 10 of a div → busy = 0, result = 0, no done; fresh start afterwards completes normally in 35 cycles.
